// File: rtl/data_memory_ctrl_if.sv
// Request/response bus and IO-port bundle for data_memory_ctrl.
// master = requester side (also plays the IO device), slave = the controller.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               rsp_ready, io_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, io_we, io_addr, io_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
               rsp_ready, io_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, io_we, io_addr, io_wdata
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data RAM with sized/extended loads and a memory-mapped IO window.
// Optional macro DMEM_INIT_CLEAR_EN adds a post-reset sweep that zeroes the RAM.
module data_memory_ctrl #(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_CLEAR = 2'd0, ST_IDLE = 2'd1, ST_RESP = 2'd2} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd1, ST_RESP = 2'd2} state_t;
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    typedef struct packed {
        logic        load;      // successful load: rdata is meaningful
        logic        err;
        logic        io;
        logic [1:0]  off;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] io_rdata;
    } rsp_ctx_t;

    state_t            state_q, state_d;
    rsp_ctx_t          rsp_q, rsp_d;
    logic              io_we_q, io_we_d;
    logic [31:0]       io_addr_q, io_addr_d;
    logic [31:0]       io_wdata_q, io_wdata_d;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       mem_rdata_q;
`ifdef DMEM_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
`endif

    logic              accept, req_err, req_io;
    logic [1:0]        req_off;
    logic [ADDR_W-1:0] req_idx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;

    assign req_off       = bus.req_addr[1:0];
    assign req_idx       = bus.req_addr[ADDR_W+1:2];
    assign req_io        = bus.req_addr >= IO_BASE;
    assign bus.req_ready = rst_n && (state_q == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_err       = (bus.req_size == 2'b11) ||
                           (bus.req_size == 2'b01 && req_off[0]) ||
                           (bus.req_size == 2'b10 && req_off != 2'b00);

    // NOTE: always_comb uses blocking assignments with defaults first, so no latches.
    always_comb begin
        mem_we    = accept && bus.req_we && !req_err && !req_io;
        mem_waddr = req_idx;
        mem_be    = 4'b1111;
        mem_wdata = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                mem_be    = 4'b0001 << req_off;
                mem_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mem_be    = req_off[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef DMEM_INIT_CLEAR_EN
        if (rst_n && state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_idx_q;
            mem_be    = 4'b1111;
            mem_wdata = '0;
        end
`endif
    end

    // NOTE: the RAM array and its read register are deliberately not reset, so they map onto block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (accept) mem_rdata_q <= mem[req_idx];
    end

    always_comb begin
        state_d    = state_q;
        rsp_d      = rsp_q;
        io_we_d    = 1'b0;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
`ifdef DMEM_INIT_CLEAR_EN
        clear_idx_d = clear_idx_q;
`endif
        case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
            ST_CLEAR: begin
                clear_idx_d = clear_idx_q + 1'b1;
                if (clear_idx_q == '1) state_d = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    state_d        = ST_RESP;
                    rsp_d.load     = !bus.req_we && !req_err;
                    rsp_d.err      = req_err;
                    rsp_d.io       = req_io;
                    rsp_d.off      = req_off;
                    rsp_d.size     = bus.req_size;
                    rsp_d.uns      = bus.req_unsigned;
                    rsp_d.io_rdata = bus.io_rdata;
                    if (bus.req_we && !req_err && req_io) begin
                        io_we_d    = 1'b1;
                        io_addr_d  = bus.req_addr;
                        io_wdata_d = bus.req_wdata;
                    end
                end
            end
            ST_RESP: if (bus.rsp_valid && bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            rsp_q      <= '0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
`ifdef DMEM_INIT_CLEAR_EN
            clear_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rsp_q      <= rsp_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
`ifdef DMEM_INIT_CLEAR_EN
            clear_idx_q <= clear_idx_d;
`endif
        end
    end

    // Extension happens on the registered word, after the synchronous RAM read.
    logic [31:0] src_word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        src_word      = rsp_q.io ? rsp_q.io_rdata : mem_rdata_q;
        byte_v        = src_word[{rsp_q.off, 3'b000} +: 8];
        half_v        = rsp_q.off[1] ? src_word[31:16] : src_word[15:0];
        bus.rsp_rdata = '0;
        if (rsp_q.load) begin
            case (rsp_q.size)
                2'b00:   bus.rsp_rdata = {{24{!rsp_q.uns && byte_v[7]}}, byte_v};
                2'b01:   bus.rsp_rdata = {{16{!rsp_q.uns && half_v[15]}}, half_v};
                default: bus.rsp_rdata = src_word;
            endcase
        end
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = rsp_q.err;
    assign bus.io_we     = io_we_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: byte-lane memory model, directed pins, random traffic.
module tb_data_memory_ctrl;
`ifdef DMEM_INIT_CLEAR_EN
    localparam int AW    = 4;
    localparam int CLR_N = 16;
    localparam int NW    = 16;
`else
    localparam int AW    = 14;
    localparam int CLR_N = 0;
    localparam int NW    = 64;
`endif
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_ctrl_if bus ();
    data_memory_ctrl #(.ADDR_W(AW), .IO_BASE(IO_BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [1 << AW];
    int          clear_left = CLR_N;
    bit          io_pend = 0;
    logic [31:0] io_exp_addr, io_exp_wdata;
    int          rsp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    int          io_we_cnt = 0;
    logic [31:0] io_last_addr, io_last_wdata;
    longint      cyc = 0, acc_cyc = 0, prev_acc_cyc = 0;
    int          rr_mode = 1;

    // rsp_ready policy: 0 = hold low, 1 = always high, 2 = random backpressure
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Compare process + behavioural model, evaluated mid-cycle.
    always @(negedge clk) begin : mon
        logic [31:0] a, w, v;
        int          off, nb, idx;
        bit          err, io;
        exp_t        r;
        cyc++;
        if (!rst_n) begin
            check("req_ready_in_reset", bus.req_ready, 0);
            exp_q.delete();
            io_pend    = 0;
            clear_left = CLR_N;
            if (CLR_N != 0) foreach (mem_m[i]) mem_m[i] = '0;
        end else begin
            check("req_ready", bus.req_ready, (exp_q.size() == 0 && clear_left == 0));
            check("rsp_valid", bus.rsp_valid, (exp_q.size() != 0));
            if (bus.rsp_valid && exp_q.size() != 0) begin
                check("rsp_rdata", bus.rsp_rdata, exp_q[0].rdata);
                check("rsp_err", bus.rsp_err, exp_q[0].err);
                if (bus.rsp_ready) begin
                    last_rdata = bus.rsp_rdata;
                    last_err   = bus.rsp_err;
                    void'(exp_q.pop_front());
                    rsp_count++;
                end
            end
            check("io_we", bus.io_we, io_pend);
            if (bus.io_we) begin
                io_we_cnt++;
                io_last_addr  = bus.io_addr;
                io_last_wdata = bus.io_wdata;
            end
            if (io_pend) begin
                check("io_addr", bus.io_addr, io_exp_addr);
                check("io_wdata", bus.io_wdata, io_exp_wdata);
            end
            io_pend = 0;
            if (bus.req_valid && bus.req_ready) begin
                a   = bus.req_addr;
                w   = bus.req_wdata;
                nb  = (bus.req_size == 2'b00) ? 1 : (bus.req_size == 2'b01) ? 2 : 4;
                err = (bus.req_size == 2'b11) || ((a % nb) != 0);
                io  = (a >= IO_BASE);
                off = int'(a % 4);
                idx = int'((a / 4) % (1 << AW));
                r.rdata = '0;
                r.err   = err;
                if (!err) begin
                    if (bus.req_we) begin
                        if (io) begin
                            io_pend      = 1;
                            io_exp_addr  = a;
                            io_exp_wdata = w;
                        end else begin
                            for (int k = 0; k < nb; k++) mem_m[idx][8*(off+k) +: 8] = w[8*k +: 8];
                        end
                    end else begin
                        v = io ? bus.io_rdata : mem_m[idx];
                        v = v >> (8 * off);
                        if (nb == 1)
                            v = bus.req_unsigned ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
                        else if (nb == 2)
                            v = bus.req_unsigned ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
                        r.rdata = v;
                    end
                end
                exp_q.push_back(r);
                prev_acc_cyc = acc_cyc;
                acc_cyc      = cyc;
            end
            if (clear_left > 0) clear_left--;
        end
    end

    task automatic send(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] iord);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.io_rdata     = iord;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 200);
        check("accept_wait", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int start = rsp_count;
        int n     = 0;
        while (rsp_count == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", (rsp_count != start), 1);
    endtask

    function automatic logic [31:0] mk_addr(input int idx, input int off);
        logic [31:0] a;
        a          = $urandom;
        a[AW+1:2]  = idx[AW-1:0];
        a[1:0]     = off[1:0];
        if (a >= IO_BASE) a[31] = 1'b0;
        return a;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.io_rdata     = '0;
        bus.rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        check("reset_io_we", bus.io_we, 0);
        check("reset_io_addr", bus.io_addr, 0);
        check("reset_io_wdata", bus.io_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
        begin
            int n = 0;
            while (!bus.req_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("clear_cycles", n, 16);
            for (int i = 0; i < 16; i++) begin
                send(0, 2'b10, 1, i * 4, 0, 0);
                wait_rsp();
                check("clear_word", last_rdata, 0);
            end
        end
`endif

        send(1, 2'b10, 0, 32'd0, 32'h1234_5678, 0); wait_rsp();
        send(0, 2'b00, 1, 32'd3, 0, 0);            wait_rsp();
        check("ubyte_addr3", last_rdata, 32'h0000_0012);

        send(1, 2'b10, 0, 32'd4, 32'h1122_3344, 0); wait_rsp();
        send(1, 2'b00, 0, 32'd5, 32'hABCD_EF80, 0); wait_rsp();
        send(0, 2'b00, 0, 32'd5, 0, 0);            wait_rsp();
        check("sbyte_addr5", last_rdata, 32'hFFFF_FF80);
        send(0, 2'b10, 0, 32'd4, 0, 0);            wait_rsp();
        check("word_addr4", last_rdata, 32'h1122_8044);
        send(0, 2'b01, 1, 32'd6, 0, 0);            wait_rsp();
        check("uhalf_addr6", last_rdata, 32'h0000_1122);

        send(0, 2'b10, 0, 32'd2, 0, 0);            wait_rsp();
        check("misaligned_err", last_err, 1);
        check("misaligned_rdata", last_rdata, 0);
        send(0, 2'b10, 0, 32'd0, 0, 0);            wait_rsp();
        check("after_err_rdata", last_rdata, 32'h1234_5678);
        check("after_err_err", last_err, 0);
        send(0, 2'b11, 0, 32'd0, 0, 0);            wait_rsp();
        check("size11_err", last_err, 1);

        io_we_cnt = 0;
        send(1, 2'b10, 0, IO_BASE + 4, 32'h0000_00A5, 0); wait_rsp();
        repeat (2) @(negedge clk);
        check("io_we_pulses", io_we_cnt, 1);
        check("io_addr_val", io_last_addr, IO_BASE + 4);
        check("io_wdata_val", io_last_wdata, 32'h0000_00A5);
        send(0, 2'b01, 0, IO_BASE, 0, 32'h0000_8001); wait_rsp();
        check("io_shalf", last_rdata, 32'hFFFF_8001);
        send(0, 2'b01, 1, IO_BASE, 0, 32'h0000_8001); wait_rsp();
        check("io_uhalf", last_rdata, 32'h0000_8001);

        // back-to-back loads with rsp_ready held high
        send(0, 2'b10, 0, 32'd0, 0, 0);
        send(0, 2'b10, 0, 32'd4, 0, 0);
        repeat (4) @(negedge clk);
        check("throughput_gap", 32'(acc_cyc - prev_acc_cyc), 2);

        rr_mode = 0;
        send(0, 2'b10, 0, 32'd0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_rdata", bus.rsp_rdata, 32'h1234_5678);
            check("hold_req_ready", bus.req_ready, 0);
        end
        rr_mode = 1;
        wait_rsp();

        rr_mode = 0;
        send(0, 2'b10, 0, 32'd4, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midresp_rst_valid", bus.rsp_valid, 0);
        check("midresp_rst_rdata", bus.rsp_rdata, 0);
        rst_n   = 1'b1;
        rr_mode = 1;

        // random traffic: prefill the modelled window, then mixed RAM/IO requests
        rr_mode = 2;
        for (int i = 0; i < NW; i++) send(1, 2'b10, 0, mk_addr(i, 0), $urandom, 0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) < 2) a = IO_BASE + $urandom_range(0, 1023);
            else a = mk_addr($urandom_range(0, NW - 1), $urandom_range(0, 3));
            send($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1), a,
                 $urandom, $urandom);
        end
        rr_mode = 1;
        repeat (20) @(negedge clk);
        check("drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
